// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with registered output stage and 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid; sustains one instruction per cycle.
// Backpressure: in_ready is registered and drops only while both entries are occupied.
module imm_gen_pipe #(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] pc;
    } res_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            sbit;
    logic [31:0]     imm32;
    logic [2:0]      fmt_dec;
    logic            ill_dec;
    logic            use_tgt;
    logic [XLEN-1:0] imm_dec;
    res_t            dec;

    state_t          state_q, state_d;
    logic            in_ready_q;
    res_t            out_q, skid_q;
    logic            in_fire, out_fire;
    logic            load_out_in, load_out_skid, load_skid;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    // With SIGN_EXT=0 every field is zero-extended from its own width.
    assign sbit   = SIGN_EXT ? in_instr[31] : 1'b0;

    // Decode opcode into format, legality and a 32-bit immediate.
    always_comb begin
        fmt_dec = FMT_NONE;
        ill_dec = 1'b0;
        use_tgt = 1'b0;
        imm32   = 32'd0;
        case (opcode)
            7'b0010011: begin
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    // RV64 shifts take a 6-bit shamt; bit 30 (srai) is never part of it.
                    fmt_dec = FMT_SHAMT;
                    imm32   = {26'd0, (XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]};
                end else begin
                    fmt_dec = FMT_I;
                    imm32   = {{20{sbit}}, in_instr[31:20]};
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if (funct3 == 3'd1 || funct3 == 3'd5) begin
                        fmt_dec = FMT_SHAMT;
                        imm32   = {27'd0, in_instr[24:20]};
                    end else begin
                        fmt_dec = FMT_I;
                        imm32   = {{20{sbit}}, in_instr[31:20]};
                    end
                end else begin
                    ill_dec = 1'b1;
                end
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                fmt_dec = FMT_I;
                imm32   = {{20{sbit}}, in_instr[31:20]};
            end
            7'b0100011: begin
                fmt_dec = FMT_S;
                imm32   = {{20{sbit}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                fmt_dec = FMT_B;
                use_tgt = 1'b1;
                imm32   = {{19{sbit}}, in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                fmt_dec = FMT_J;
                use_tgt = 1'b1;
                imm32   = {{11{sbit}}, in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            7'b0110111: begin
                fmt_dec = FMT_U;
                imm32   = {in_instr[31:12], 12'd0};
            end
            7'b0010111: begin
                fmt_dec = FMT_U;
                use_tgt = 1'b1;
                imm32   = {in_instr[31:12], 12'd0};
            end
            7'b0110011, 7'b0111011: begin
                fmt_dec = FMT_NONE;
            end
            default: begin
                ill_dec = 1'b1;
            end
        endcase
    end

    // Widen to XLEN; bit 31 of imm32 already carries the sign for every signed format.
    generate
        if (XLEN == 64) begin : g_x64
            assign imm_dec = {{32{SIGN_EXT & imm32[31]}}, imm32};
        end else begin : g_x32
            assign imm_dec = imm32;
        end
    endgenerate

    assign dec.imm = imm_dec;
    assign dec.fmt = fmt_dec;
    assign dec.ill = ill_dec;
    assign dec.tgt = use_tgt ? (in_pc + imm_dec) : '0;
    assign dec.pc  = in_pc;

    assign in_fire   = in_valid & in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_fire  = out_valid & out_ready;

    // Skid-buffer next state and register load selects.
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_out_in = 1'b1;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_out_skid = 1'b1;
                    state_d       = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State register; in_ready is precomputed from the next state so it is a flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Output and skid data registers; only written on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out_in) begin
                out_q <= dec;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.ill;
    assign out_target  = out_q.tgt;
    assign out_pc      = out_q.pc;

endmodule
